// File: rtl/pll_pkg.sv
// Shared types and clock-ratio constants for the PLL lock detector and its benches.
package pll_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      EVAL  = 2'd2
   } lockdet_state_t;

   // Nominal bench clocking: 100 MHz sampling clock, 2.5 MHz reference.
   localparam int unsigned CLK_PERIOD_NS = 10;
   localparam int unsigned REF_PERIOD_NS = 400;
   localparam int unsigned REF_CLK_RATIO = REF_PERIOD_NS / CLK_PERIOD_NS;

   // Subtraction that floors at zero, for tolerance limits.
   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (a > b) ? (a - b) : 0;
   endfunction

endpackage

// File: rtl/pll_lock_detect_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic s1_q, s2_q, dly_q, rise_q;

   // Synchronize the asynchronous input and emit a one-cycle pulse on its rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         dly_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= async_i;
         s2_q   <= s1_q;
         dly_q  <= s2_q;
         rise_q <= s2_q & ~dly_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/pll_lock_detect.sv
// Frequency lock detector: counts feedback edges per window of reference edges.
module pll_lock_detect
   import pll_pkg::*;
#(
   parameter int unsigned WIN_REF   = 8,
   parameter int unsigned TOL       = 1,
   parameter int unsigned LOCK_WINS = 4,
   parameter int unsigned TIMEOUT   = 256,
   parameter int unsigned CW        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ref_in,
   input  logic          clk_fb,
   output logic          locked,
   output logic          fast,
   output logic          slow,
   output logic          ref_lost,
   output logic          win_done,
   output logic [CW-1:0] fb_count
);

   localparam int unsigned RW = $clog2(WIN_REF + 1);
   localparam int unsigned GW = $clog2(LOCK_WINS + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam int unsigned XW = CW + 1;
   localparam logic [XW-1:0] HI_LIM = XW'(WIN_REF + TOL);
   localparam logic [XW-1:0] LO_LIM = XW'(sat_sub(WIN_REF, TOL));

   logic           ref_rise, fb_rise;
   lockdet_state_t state_q, state_d;
   logic [RW-1:0]  ref_cnt_q, ref_cnt_d;
   logic [CW-1:0]  fb_cnt_q, fb_cnt_d, fb_inc;
   logic [GW-1:0]  good_cnt_q, good_cnt_d;
   logic [WW-1:0]  wd_q, wd_d;
   logic [CW-1:0]  fb_count_q, fb_count_d;
   logic           fast_q, fast_d, slow_q, slow_d;
   logic           locked_q, locked_d, ref_lost_q, ref_lost_d;
   logic           win_fast, win_slow, timeout_hit;

   edge_sync u_ref_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ref_in),
      .rise_o  (ref_rise)
   );

   edge_sync u_fb_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (clk_fb),
      .rise_o  (fb_rise)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ref_cnt_q  <= '0;
         fb_cnt_q   <= '0;
         good_cnt_q <= '0;
         wd_q       <= '0;
         fb_count_q <= '0;
         fast_q     <= 1'b0;
         slow_q     <= 1'b0;
         locked_q   <= 1'b0;
         ref_lost_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_cnt_q  <= ref_cnt_d;
         fb_cnt_q   <= fb_cnt_d;
         good_cnt_q <= good_cnt_d;
         wd_q       <= wd_d;
         fb_count_q <= fb_count_d;
         fast_q     <= fast_d;
         slow_q     <= slow_d;
         locked_q   <= locked_d;
         ref_lost_q <= ref_lost_d;
      end
   end

   // Window FSM, window evaluation, lock qualification and reference watchdog.
   always_comb begin
      state_d    = state_q;
      ref_cnt_d  = ref_cnt_q;
      fb_cnt_d   = fb_cnt_q;
      good_cnt_d = good_cnt_q;
      fb_count_d = fb_count_q;
      fast_d     = fast_q;
      slow_d     = slow_q;
      locked_d   = locked_q;
      ref_lost_d = ref_lost_q;

      // Count including a feedback edge in this cycle, so the closing cycle is not lost.
      fb_inc   = (fb_rise && (fb_cnt_q != '1)) ? fb_cnt_q + CW'(1) : fb_cnt_q;
      win_fast = {1'b0, fb_inc} > HI_LIM;
      win_slow = {1'b0, fb_inc} < LO_LIM;

      wd_d        = ref_rise ? '0 : ((wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + WW'(1));
      timeout_hit = !ref_rise && (wd_q >= WW'(TIMEOUT - 1));

      if (ref_rise) begin
         ref_lost_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ref_rise) begin
               ref_cnt_d = '0;
               fb_cnt_d  = '0;
               state_d   = COUNT;
            end
         end
         COUNT, EVAL: begin
            // EVAL lasts one cycle but keeps counting into the window that just opened.
            state_d  = COUNT;
            fb_cnt_d = fb_inc;
            if (ref_rise) begin
               if (ref_cnt_q == RW'(WIN_REF - 1)) begin
                  fb_count_d = fb_inc;
                  fast_d     = win_fast;
                  slow_d     = win_slow;
                  ref_cnt_d  = '0;
                  fb_cnt_d   = '0;
                  state_d    = EVAL;
                  if (!win_fast && !win_slow) begin
                     if (good_cnt_q != GW'(LOCK_WINS)) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                     end
                     locked_d = (good_cnt_d == GW'(LOCK_WINS));
                  end else begin
                     good_cnt_d = '0;
                     locked_d   = 1'b0;
                  end
               end else begin
                  ref_cnt_d = ref_cnt_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         ref_lost_d = 1'b1;
         locked_d   = 1'b0;
         good_cnt_d = '0;
         fast_d     = 1'b0;
         slow_d     = 1'b0;
         state_d    = IDLE;
      end
   end

   assign locked   = locked_q;
   assign fast     = fast_q;
   assign slow     = slow_q;
   assign ref_lost = ref_lost_q;
   assign win_done = (state_q == EVAL);
   assign fb_count = fb_count_q;

endmodule
